// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing for the in-order core.
// Drives IF/ID and ID/EX register controls and PC write enable, resolving
// external memory stalls, taken-branch flushes, multi-cycle EX ops and
// load-use hazards. Keeps free-running stall and flush counters.
// Stage control encoding: 2'b01 run, 2'b00 flush, 2'b10 stall.
// There is no valid/ready handshake here: every control output is a
// per-cycle level that the pipeline registers obey unconditionally.
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,   // stall cycles of a multi-cycle op, 1..255
    parameter int CNT_W  = 32
) (
    input  logic             cpu_clk,
    input  logic             reset,        // asynchronous, active low
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_is_mc,
    input  logic             br_taken,
    input  logic             ext_stall,
    output logic [1:0]       enb_if_id,
    output logic [1:0]       enb_id_ex,
    output logic             pc_we,
    output logic             haz,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MCBUSY = 2'd1,
        MCDONE = 2'd2
    } state_t;

    localparam logic [1:0] ENB_RUN   = 2'b01;
    localparam logic [1:0] ENB_FLUSH = 2'b00;
    localparam logic [1:0] ENB_STALL = 2'b10;
    localparam logic [7:0] MC_INIT   = 8'(MC_LAT - 1);

    state_t     state, state_nx;
    logic [7:0] mc_cnt, mc_nx;
    logic       flush_inc;
    logic       lu;

    // Load-use: EX load writes a nonzero register the IF/ID instruction reads.
    assign lu = ex_is_load && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    assign dbg_state = state;

    // Next-state and Mealy outputs; reset low forces all controls off.
    always_comb begin
        state_nx  = state;
        mc_nx     = mc_cnt;
        flush_inc = 1'b0;
        enb_if_id = ENB_RUN;
        enb_id_ex = ENB_RUN;
        pc_we     = 1'b1;
        haz       = 1'b0;
        if (ext_stall) begin
            // Freeze the front end; state and mc_cnt hold in every state.
            enb_if_id = ENB_STALL;
            enb_id_ex = ENB_STALL;
            pc_we     = 1'b0;
            haz       = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (br_taken) begin
                        enb_if_id = ENB_FLUSH;
                        enb_id_ex = ENB_FLUSH;
                        flush_inc = 1'b1;
                    end else if (ex_is_mc) begin
                        enb_if_id = ENB_STALL;
                        enb_id_ex = ENB_STALL;
                        pc_we     = 1'b0;
                        haz       = 1'b1;
                        mc_nx     = MC_INIT;
                        state_nx  = (MC_LAT == 1) ? MCDONE : MCBUSY;
                    end else if (lu) begin
                        enb_if_id = ENB_STALL;
                        enb_id_ex = ENB_FLUSH;
                        pc_we     = 1'b0;
                        haz       = 1'b1;
                    end
                end
                MCBUSY: begin
                    // Branch and load-use cannot apply while the op owns EX.
                    enb_if_id = ENB_STALL;
                    enb_id_ex = ENB_STALL;
                    pc_we     = 1'b0;
                    haz       = 1'b1;
                    mc_nx     = mc_cnt - 8'd1;
                    if (mc_cnt == 8'd1) state_nx = MCDONE;
                end
                MCDONE: begin
                    // The op leaves EX now, so ex_is_mc is still high but stale.
                    if (lu) begin
                        enb_if_id = ENB_STALL;
                        enb_id_ex = ENB_FLUSH;
                        pc_we     = 1'b0;
                        haz       = 1'b1;
                    end
                    state_nx = RUN;
                end
                default: state_nx = RUN;
            endcase
        end
        if (!reset) begin
            enb_if_id = ENB_FLUSH;
            enb_id_ex = ENB_FLUSH;
            pc_we     = 1'b0;
            haz       = 1'b0;
            flush_inc = 1'b0;
        end
    end

    // State register and multi-cycle down-counter.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            mc_cnt <= 8'd0;
        end else begin
            state  <= state_nx;
            mc_cnt <= mc_nx;
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (haz)       stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (flush_inc) flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Three instances share the same stimulus:
// a: MC_LAT=4 CNT_W=32, b: MC_LAT=1 CNT_W=32, c: MC_LAT=4 CNT_W=4.
module tb_pipe_hazard_ctrl;

    logic       cpu_clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_is_load, ex_is_mc, br_taken, ext_stall;

    logic [1:0]  a_if, a_ex, b_if, b_ex, c_if, c_ex;
    logic        a_pc, a_haz, b_pc, b_haz, c_pc, c_haz;
    logic [31:0] a_stall, a_flush, b_stall, b_flush;
    logic [3:0]  c_stall, c_flush;
    logic [1:0]  a_dbg, b_dbg, c_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 cpu_clk = ~cpu_clk;

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(32)) u_a (
        .cpu_clk(cpu_clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_is_mc(ex_is_mc), .br_taken(br_taken), .ext_stall(ext_stall),
        .enb_if_id(a_if), .enb_id_ex(a_ex), .pc_we(a_pc), .haz(a_haz),
        .stall_cnt(a_stall), .flush_cnt(a_flush), .dbg_state(a_dbg));

    pipe_hazard_ctrl #(.MC_LAT(1), .CNT_W(32)) u_b (
        .cpu_clk(cpu_clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_is_mc(ex_is_mc), .br_taken(br_taken), .ext_stall(ext_stall),
        .enb_if_id(b_if), .enb_id_ex(b_ex), .pc_we(b_pc), .haz(b_haz),
        .stall_cnt(b_stall), .flush_cnt(b_flush), .dbg_state(b_dbg));

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) u_c (
        .cpu_clk(cpu_clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_is_mc(ex_is_mc), .br_taken(br_taken), .ext_stall(ext_stall),
        .enb_if_id(c_if), .enb_id_ex(c_ex), .pc_we(c_pc), .haz(c_haz),
        .stall_cnt(c_stall), .flush_cnt(c_flush), .dbg_state(c_dbg));

    // Output bundles {enb_if_id, enb_id_ex, pc_we, haz} per instance.
    logic [5:0]  o_vec[3];
    logic [31:0] o_stall[3];
    logic [31:0] o_flush[3];
    assign o_vec[0]   = {a_if, a_ex, a_pc, a_haz};
    assign o_vec[1]   = {b_if, b_ex, b_pc, b_haz};
    assign o_vec[2]   = {c_if, c_ex, c_pc, c_haz};
    assign o_stall[0] = a_stall;
    assign o_stall[1] = b_stall;
    assign o_stall[2] = {28'd0, c_stall};
    assign o_flush[0] = a_flush;
    assign o_flush[1] = b_flush;
    assign o_flush[2] = {28'd0, c_flush};

    localparam logic [5:0] V_RUN   = 6'b01_01_1_0;
    localparam logic [5:0] V_STALL = 6'b10_10_0_1;
    localparam logic [5:0] V_BUBBL = 6'b10_00_0_1;
    localparam logic [5:0] V_FLUSH = 6'b00_00_1_0;
    localparam logic [5:0] V_OFF   = 6'b00_00_0_0;

    // ---------------- reference model ----------------
    // Tracks an outstanding multi-cycle op as "stall cycles still owed" plus
    // a flag for the release cycle in which the op leaves EX.
    int          m_left[3];
    bit          m_done[3];
    logic [31:0] m_stall[3];
    logic [31:0] m_flush[3];
    int          m_lat[3] = '{4, 1, 4};
    logic [31:0] m_mask[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

    function automatic logic [5:0] model_out(int k);
        logic lu;
        lu = ex_is_load && (ex_rd != 0) &&
             (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        if (!reset) return V_OFF;
        if (ext_stall || m_left[k] > 0) return V_STALL;
        if (m_done[k]) return lu ? V_BUBBL : V_RUN;
        if (br_taken) return V_FLUSH;
        if (ex_is_mc) return V_STALL;
        if (lu) return V_BUBBL;
        return V_RUN;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_done[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs2 = 0;
        ex_is_load = 0; ex_is_mc = 0; br_taken = 0; ext_stall = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_is_load = 1; ex_rd = r; id_rs1 = r;
    endtask

    // One clock: advance the model with the current inputs, return at negedge.
    task automatic step();
        logic [5:0] e[3];
        for (int k = 0; k < 3; k++) e[k] = model_out(k);
        @(posedge cpu_clk);
        if (!reset) model_zero();
        else begin
            for (int k = 0; k < 3; k++) begin
                m_stall[k] = m_stall[k] + {31'd0, e[k][0]};
                if (!ext_stall) begin
                    if (m_left[k] > 0) begin
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) m_done[k] = 1;
                    end else if (m_done[k]) m_done[k] = 0;
                    else if (br_taken) m_flush[k] = m_flush[k] + 1;
                    else if (ex_is_mc) begin
                        m_left[k] = m_lat[k] - 1;
                        if (m_left[k] == 0) m_done[k] = 1;
                    end
                end
            end
        end
        @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        reset = 0;
        set_idle();
        model_zero();
        step();
        step();
        reset = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_vec[k] !== V_OFF || o_stall[k] !== 0 || o_flush[k] !== 0) begin
                n_fail++;
                $display("FAIL reset_hold inst%0d: out=%b st=%0d fl=%0d, want out=%b st=0 fl=0",
                         k, o_vec[k], o_stall[k], o_flush[k], V_OFF);
            end
        end
        step();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (o_vec[0] !== V_RUN || a_stall !== 0) begin
                n_fail++;
                $display("FAIL idle_run cyc%0d: out=%b st=%0d, want %b st=0", i, o_vec[0], a_stall, V_RUN);
            end
            step();
        end
        set_lu(5'd9);
        step();
        set_idle();
        #1;
        n_tests++;
        if (a_stall !== 1) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got %0d want 1", a_stall);
        end
        reset = 0;
        model_zero();
        #1;
        n_tests++;
        if (o_vec[0] !== V_OFF || a_stall !== 0 || a_flush !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_run: out=%b st=%0d fl=%0d, want %b 0 0", o_vec[0], a_stall, a_flush, V_OFF);
        end
        step();
        reset = 1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu(5'd5);
        #1;
        n_tests++;
        if (o_vec[0] !== V_BUBBL) begin
            n_fail++;
            $display("FAIL lu_rs1: got %b want %b", o_vec[0], V_BUBBL);
        end
        step();
        set_idle();
        #1;
        n_tests++;
        if (a_stall !== 1 || o_vec[0] !== V_RUN) begin
            n_fail++;
            $display("FAIL lu_after: st=%0d out=%b, want st=1 out=%b", a_stall, o_vec[0], V_RUN);
        end
        step();
        set_lu(5'd0);
        #1;
        n_tests++;
        if (o_vec[0] !== V_RUN) begin
            n_fail++;
            $display("FAIL lu_x0: got %b want %b", o_vec[0], V_RUN);
        end
        step();
        set_idle();
        ex_is_load = 1; ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 1;
        #1;
        n_tests++;
        if (o_vec[0] !== V_BUBBL) begin
            n_fail++;
            $display("FAIL lu_rs2: got %b want %b", o_vec[0], V_BUBBL);
        end
        id_uses_rs2 = 0;
        #1;
        n_tests++;
        if (o_vec[0] !== V_RUN) begin
            n_fail++;
            $display("FAIL lu_rs2_unused: got %b want %b", o_vec[0], V_RUN);
        end
        step();
        set_idle();
    endtask

    task automatic test_multicycle();
        do_reset();
        ex_is_mc = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (o_vec[0] !== V_STALL || o_vec[2] !== V_STALL) begin
                n_fail++;
                $display("FAIL mc_stall cyc%0d: a=%b c=%b want %b", i, o_vec[0], o_vec[2], V_STALL);
            end
            if (i < 2) begin
                n_tests++;
                if (o_vec[1] !== (i == 0 ? V_STALL : V_RUN)) begin
                    n_fail++;
                    $display("FAIL mc_lat1 cyc%0d: got %b want %b", i, o_vec[1], (i == 0 ? V_STALL : V_RUN));
                end
            end
            if (i == 2) begin
                n_tests++;
                if (b_stall !== 1) begin
                    n_fail++;
                    $display("FAIL mc_lat1_cnt: got %0d want 1", b_stall);
                end
            end
            step();
        end
        #1;
        n_tests++;
        if (o_vec[0] !== V_RUN) begin
            n_fail++;
            $display("FAIL mc_done_no_retrigger: got %b want %b", o_vec[0], V_RUN);
        end
        step();
        ex_is_mc = 0;
        #1;
        n_tests++;
        if (a_stall !== 4 || c_stall !== 4'd4 || o_vec[0] !== V_RUN) begin
            n_fail++;
            $display("FAIL mc_count: a=%0d c=%0d out=%b, want 4 4 %b", a_stall, c_stall, o_vec[0], V_RUN);
        end
        step();
    endtask

    task automatic test_branch();
        do_reset();
        set_lu(5'd5);
        br_taken = 1;
        #1;
        n_tests++;
        if (o_vec[0] !== V_FLUSH) begin
            n_fail++;
            $display("FAIL br_over_lu: got %b want %b", o_vec[0], V_FLUSH);
        end
        step();
        set_idle();
        #1;
        n_tests++;
        if (a_flush !== 1 || a_stall !== 0 || o_vec[0] !== V_RUN) begin
            n_fail++;
            $display("FAIL br_count: fl=%0d st=%0d out=%b, want 1 0 %b", a_flush, a_stall, o_vec[0], V_RUN);
        end
        step();
    endtask

    task automatic test_ext_stall_mc();
        bit ext_pat[7] = '{0, 0, 1, 1, 0, 0, 0};
        do_reset();
        ex_is_mc = 1;
        for (int i = 0; i < 7; i++) begin
            ext_stall = ext_pat[i];
            br_taken  = (i == 4);
            #1;
            n_tests++;
            if (o_vec[0] !== (i < 6 ? V_STALL : V_RUN)) begin
                n_fail++;
                $display("FAIL ext_mc cyc%0d: got %b want %b", i, o_vec[0], (i < 6 ? V_STALL : V_RUN));
            end
            step();
        end
        set_idle();
        #1;
        n_tests++;
        if (a_stall !== 6 || a_flush !== 0) begin
            n_fail++;
            $display("FAIL ext_mc_count: st=%0d fl=%0d, want 6 0", a_stall, a_flush);
        end
        step();
    endtask

    task automatic test_counter_wrap();
        logic [3:0] want;
        do_reset();
        set_lu(5'd12);
        for (int i = 0; i < 16; i++) begin
            want = 4'(i);
            #1;
            n_tests++;
            if (c_stall !== want) begin
                n_fail++;
                $display("FAIL wrap_progress cyc%0d: got %0d want %0d", i, c_stall, want);
            end
            step();
        end
        set_idle();
        #1;
        n_tests++;
        if (c_stall !== 4'd0 || a_stall !== 16) begin
            n_fail++;
            $display("FAIL wrap_zero: c=%0d a=%0d, want 0 16", c_stall, a_stall);
        end
        step();
    endtask

    task automatic test_random();
        logic [5:0] e;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 0;
                model_zero();
            end else reset = 1;
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_is_mc    = ($urandom_range(0, 9) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            ext_stall   = ($urandom_range(0, 9) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                e = model_out(k);
                n_tests++;
                if (o_vec[k] !== e) begin
                    n_fail++;
                    $display("FAIL rand_out n%0d inst%0d: got %b want %b", n, k, o_vec[k], e);
                end
                n_tests++;
                if (o_stall[k] !== (m_stall[k] & m_mask[k])) begin
                    n_fail++;
                    $display("FAIL rand_stall n%0d inst%0d: got %0d want %0d", n, k, o_stall[k], m_stall[k] & m_mask[k]);
                end
                n_tests++;
                if (o_flush[k] !== (m_flush[k] & m_mask[k])) begin
                    n_fail++;
                    $display("FAIL rand_flush n%0d inst%0d: got %0d want %0d", n, k, o_flush[k], m_flush[k] & m_mask[k]);
                end
            end
            step();
        end
        reset = 1;
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_idle();
        model_zero();
        @(negedge cpu_clk);
        test_reset();
        test_load_use();
        test_multicycle();
        test_branch();
        test_ext_stall_mc();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the in-order core. Each cycle it generates the 2-bit `enb` control for the IF/ID stage register, the `enb` control for the ID/EX register, and the PC write enable. It resolves four conditions: load-use hazards, taken-branch flushes, multi-cycle execute ops and external memory stalls. It sits beside the decode stage, takes register indices from IF/ID and control flags from EX, and keeps stall/flush performance counters.

## Interface
- `MC_LAT`, default 4: stall cycles a multi-cycle EX op imposes; legal range 1..255.
- `CNT_W`, default 32: width of the performance counters.
- `cpu_clk` in 1: core clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_rs1` in 5: rs1 of the instruction in IF/ID.
- `id_rs2` in 5: rs2 of the instruction in IF/ID.
- `id_uses_rs2` in 1: IF/ID instruction reads rs2.
- `ex_rd` in 5: rd of the instruction in EX.
- `ex_is_load` in 1: EX instruction is a load.
- `ex_is_mc` in 1: EX instruction is multi-cycle (mul/div).
- `br_taken` in 1: EX resolved a taken branch or jump this cycle.
- `ext_stall` in 1: memory not ready; freeze the front end.
- `enb_if_id` out 2: IF/ID control. 2'b01 = run, 2'b00 = flush, 2'b10 = stall.
- `enb_id_ex` out 2: ID/EX control, same encoding.
- `pc_we` out 1: PC register update enable.
- `haz` out 1: high in every stall cycle.
- `stall_cnt` out CNT_W: count of cycles with `haz`=1.
- `flush_cnt` out CNT_W: count of branch flushes.

## Operation
- States: RUN, MCBUSY, MCDONE. A down-counter `mc_cnt` is 8 bits wide.
- `enb_*`, `pc_we` and `haz` are combinational from the state and current inputs (Mealy).
- Load-use condition `lu`: `ex_is_load` && `ex_rd`!=0 && (`ex_rd`==`id_rs1` || (`id_uses_rs2` && `ex_rd`==`id_rs2`)).
- Priority in RUN, highest first; the first matching row applies:
  - `ext_stall`: enb both 10, `pc_we`=0, `haz`=1. State, `mc_cnt` and `flush_cnt` are held.
  - `br_taken`: enb both 00, `pc_we`=1, `haz`=0. `flush_cnt`+1. Stay in RUN.
  - `ex_is_mc`: enb both 10, `pc_we`=0, `haz`=1. `mc_cnt`<=MC_LAT-1. Next state is MCDONE if MC_LAT==1, else MCBUSY.
  - `lu`: `enb_if_id`=10, `enb_id_ex`=00 (bubble), `pc_we`=0, `haz`=1. Stay in RUN. The bubble clears the condition on the next cycle.
  - Otherwise: enb both 01, `pc_we`=1, `haz`=0.
- MCBUSY:
  - `ext_stall` high: hold everything, outputs as in the RUN `ext_stall` row.
  - Otherwise: enb both 10, `pc_we`=0, `haz`=1.
  - If `mc_cnt`==1, next state is MCDONE; otherwise `mc_cnt`-1.
  - `br_taken` and `lu` are ignored.
- MCDONE:
  - `ext_stall` high: hold.
  - Otherwise: `ex_is_mc` is ignored (the op is leaving EX). `lu` is evaluated as in RUN; with no `lu`, outputs are run. Next state is RUN.
- `stall_cnt` increments on every cycle with `haz`=1. `flush_cnt` increments on each accepted flush. Both wrap modulo 2^CNT_W.

## Timing
- Reset low: state=RUN, `mc_cnt`=0, both counters 0.
- Outputs forced while reset is low: enb both 00, `pc_we`=0, `haz`=0.
- Reset asserted mid-MCBUSY abandons the multi-cycle op immediately; no residual stall after release.
- First edge after reset release behaves as RUN.
- Multi-cycle op:
  - Stall cycles = MC_LAT (entry cycle + MC_LAT-1 MCBUSY cycles).
  - The op occupies EX for MC_LAT+1 cycles and advances in the MCDONE cycle.
  - Cycles lost to `ext_stall` are added to this.
- Load-use costs exactly 1 stall cycle.
- Branch costs 1 flush cycle; the target fetch follows on the next cycle.
- Counter wrap: `stall_cnt`=2^CNT_W-1 plus one stall cycle gives 0, with no flag.

## Test plan
- Reset, then idle with no hazards: enb both 01, `pc_we`=1 every cycle. Assert reset mid-run: outputs go to 00/00/0 in the same cycle, counters go to 0.
- `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5 for one cycle: `enb_if_id`=10, `enb_id_ex`=00, `haz`=1, `stall_cnt`=1. Same stimulus with `ex_rd`=0: no stall.
- `ex_is_mc`=1 held, MC_LAT=4: exactly 4 cycles with enb 10/10, then one MCDONE run cycle with `ex_is_mc` still 1 causing no re-trigger, `stall_cnt`=4. Repeat with MC_LAT=1: 1 stall cycle.
- `br_taken`=1 together with `lu`=1: enb 00/00, `pc_we`=1, `flush_cnt`=1, `stall_cnt` unchanged.
- `ext_stall` pulsed for 2 cycles during MCBUSY with MC_LAT=4: total 6 stall cycles, `mc_cnt` frozen while `ext_stall` is high.
- CNT_W=4, 16 load-use stalls: `stall_cnt` wraps to 0.
